// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation encoding, FSM states and
// width helpers for the default 32-bit configuration.
package alu_pkg;

    localparam int N_DEFAULT    = 32;
    localparam int SHW_DEFAULT  = $clog2(N_DEFAULT);
    localparam int CNTW_DEFAULT = $clog2(N_DEFAULT) + 1;

    typedef enum logic [3:0] {
        MODE_NOP  = 4'h0,
        MODE_ADD  = 4'h1,
        MODE_SUB  = 4'h2,
        MODE_MUL  = 4'h3,
        MODE_DIV  = 4'h4,
        MODE_AND  = 4'h5,
        MODE_OR   = 4'h6,
        MODE_XOR  = 4'h7,
        MODE_NOR  = 4'h8,
        MODE_SLL  = 4'h9,
        MODE_SRL  = 4'hA,
        MODE_SLT  = 4'hB,
        MODE_MFLO = 4'hC,
        MODE_MFHI = 4'hD,
        MODE_EQ   = 4'hE,
        MODE_NEQ  = 4'hF
    } alu_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared one-bit-per-cycle shift-add multiplier / restoring divider working on
// operand magnitudes, with sign correction applied on the result outputs.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter bit SIGNED_MD = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    typedef struct packed {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
    } acc_t;

    acc_t         acc_reg;
    logic [N-1:0] opnd_reg;
    logic [N-1:0] a_reg;
    logic         is_div_reg;
    logic         neg_main_reg;
    logic         neg_rem_reg;
    logic         div_zero_reg;

    logic         a_neg, b_neg;
    logic [N-1:0] a_mag, b_mag;
    acc_t         init_acc;
    logic [N-1:0] init_opnd;

    // MUL: hi accumulates, lo holds the multiplier shifting out LSB-first.
    // DIV: hi is the partial remainder, lo the dividend turning into the quotient.
    function automatic acc_t iterate(input acc_t cur, input logic [N-1:0] d, input logic div);
        acc_t       nxt;
        logic [N:0]   sum;
        logic [N+1:0] trial;
        nxt   = cur;
        sum   = '0;
        trial = '0;
        if (div) begin
            trial  = {1'b0, cur.hi, cur.lo[N-1]} - {2'b00, d};
            nxt.hi = trial[N+1] ? {cur.hi[N-2:0], cur.lo[N-1]} : trial[N-1:0];
            nxt.lo = {cur.lo[N-2:0], ~trial[N+1]};
        end else begin
            sum    = {1'b0, cur.hi} + (cur.lo[0] ? {1'b0, d} : {(N+1){1'b0}});
            nxt.hi = sum[N:1];
            nxt.lo = {sum[0], cur.lo[N-1:1]};
        end
        return nxt;
    endfunction

    always_comb begin
        a_neg = SIGNED_MD && a[N-1];
        b_neg = SIGNED_MD && b[N-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
        init_acc.hi = '0;
        init_acc.lo = is_div ? a_mag : b_mag;
        init_opnd   = is_div ? b_mag : a_mag;
    end

    // The first iteration is folded into the load cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg      <= '0;
            opnd_reg     <= '0;
            a_reg        <= '0;
            is_div_reg   <= 1'b0;
            neg_main_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
        end else if (load) begin
            acc_reg      <= iterate(init_acc, init_opnd, is_div);
            opnd_reg     <= init_opnd;
            a_reg        <= a;
            is_div_reg   <= is_div;
            neg_main_reg <= a_neg ^ b_neg;
            neg_rem_reg  <= a_neg;
            div_zero_reg <= (b == '0);
        end else if (step) begin
            acc_reg <= iterate(acc_reg, opnd_reg, is_div_reg);
        end
    end

    logic [2*N-1:0] prod;
    logic [N-1:0]   quot, rem;

    always_comb begin
        prod = neg_main_reg ? (~acc_reg + 1'b1) : acc_reg;
        quot = neg_main_reg ? (~acc_reg.lo + 1'b1) : acc_reg.lo;
        rem  = neg_rem_reg  ? (~acc_reg.hi + 1'b1) : acc_reg.hi;
        hi   = prod[2*N-1:N];
        lo   = prod[N-1:0];
        if (is_div_reg) begin
            hi = div_zero_reg ? a_reg : rem;
            lo = div_zero_reg ? '1 : quot;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the execute stage: valid/ready handshake, single-cycle
// logic/arith ops, iterative MUL/DIV writing architectural HI/LO.
module alu_mc
    import alu_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter bit SIGNED_MD = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [3:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic         busy
);

    localparam int SHW  = $clog2(N);
    localparam int CNTW = $clog2(N) + 1;

    state_e          state_reg, state_next;
    logic [CNTW-1:0] count_reg, count_next;
    logic [N-1:0]    z_reg, hi_reg, lo_reg;
    logic            out_valid_reg;

    alu_mode_e       mode_e;
    logic            accept, is_md, load_md, step_md, fix_md;
    logic [N-1:0]    alu_res, md_hi, md_lo;
    logic [SHW-1:0]  shamt;

    assign mode_e    = alu_mode_e'(mode);
    assign in_ready  = (state_reg == S_IDLE) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_md     = (mode_e == MODE_MUL) || (mode_e == MODE_DIV);
    assign busy      = (state_reg != S_IDLE);
    assign out_valid = out_valid_reg;
    assign z         = z_reg;
    assign shamt     = y[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (mode_e)
            MODE_ADD:  alu_res = x + y;
            MODE_SUB:  alu_res = x - y;
            MODE_AND:  alu_res = x & y;
            MODE_OR:   alu_res = x | y;
            MODE_XOR:  alu_res = x ^ y;
            MODE_NOR:  alu_res = ~(x | y);
            MODE_SLL:  alu_res = x << shamt;
            MODE_SRL:  alu_res = x >> shamt;
            MODE_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(x) < $signed(y))};
            MODE_MFLO: alu_res = lo_reg;
            MODE_MFHI: alu_res = hi_reg;
            MODE_EQ:   alu_res = {{(N-1){1'b0}}, (x == y)};
            MODE_NEQ:  alu_res = {{(N-1){1'b0}}, (x != y)};
            default:   alu_res = '0;
        endcase
    end

    // Iteration 0 happens on the accept edge, so MUL/DIV hold count 1..N-1.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        load_md    = 1'b0;
        step_md    = 1'b0;
        fix_md     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept && is_md) begin
                    load_md    = 1'b1;
                    count_next = CNTW'(1);
                    state_next = (mode_e == MODE_MUL) ? S_MUL : S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                step_md = 1'b1;
                if (count_reg == CNTW'(N - 1)) begin
                    count_next = '0;
                    state_next = S_FIX;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            S_FIX: begin
                fix_md     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            count_reg     <= '0;
            z_reg         <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (fix_md) begin
                hi_reg        <= md_hi;
                lo_reg        <= md_lo;
                z_reg         <= md_lo;
                out_valid_reg <= 1'b1;
            end else if (accept && !is_md) begin
                z_reg         <= alu_res;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    alu_muldiv_iter #(
        .N         (N),
        .SIGNED_MD (SIGNED_MD)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_md),
        .step   (step_md),
        .is_div (mode_e == MODE_DIV),
        .a      (x),
        .b      (y),
        .hi     (md_hi),
        .lo     (md_lo)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: scoreboard queue of expected results, signed and
// unsigned MUL/DIV instances, backpressure and mid-operation reset.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         d_valid;
    logic [3:0]   d_mode;
    logic [N-1:0] d_x, d_y;
    logic         out_ready;
    logic         use_u;

    logic         in_valid_s, in_ready_s, out_valid_s, busy_s;
    logic [N-1:0] z_s;
    logic         in_valid_u, in_ready_u, out_valid_u, busy_u;
    logic [N-1:0] z_u;

    logic         o_in_ready, o_out_valid, o_busy;
    logic [N-1:0] o_z;

    assign in_valid_s  = d_valid & ~use_u;
    assign in_valid_u  = d_valid & use_u;
    assign o_in_ready  = use_u ? in_ready_u  : in_ready_s;
    assign o_out_valid = use_u ? out_valid_u : out_valid_s;
    assign o_busy      = use_u ? busy_u      : busy_s;
    assign o_z         = use_u ? z_u         : z_s;

    alu_mc #(.N(N), .SIGNED_MD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .x(d_x), .y(d_y), .mode(d_mode), .out_valid(out_valid_s),
        .out_ready(out_ready), .z(z_s), .busy(busy_s)
    );

    alu_mc #(.N(N), .SIGNED_MD(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_u), .in_ready(in_ready_u),
        .x(d_x), .y(d_y), .mode(d_mode), .out_valid(out_valid_u),
        .out_ready(out_ready), .z(z_u), .busy(busy_u)
    );

    logic [N-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %h expected %h", n_vec, tag, obs, exp);
    endtask

    // Called on a negedge; returns on the negedge after the accept edge.
    task automatic send(input alu_mode_e m, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] e);
        int w = 0;
        d_mode  = m;
        d_x     = a;
        d_y     = b;
        d_valid = 1'b1;
        #1;
        while (o_in_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("accept", {31'b0, o_in_ready}, 1);
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
        d_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int exp_lat);
        int           cyc = 0;
        logic         held = 1'b1;
        logic [N-1:0] e;
        while (o_out_valid !== 1'b1 && cyc < 100) begin
            if (o_in_ready !== 1'b0 || o_busy !== 1'b1) held = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, N'(cyc + 1), N'(exp_lat));
        if (exp_lat > 1) chk({tag, "_stall"}, {31'b0, held}, 1);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, o_z, e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input string tag, input alu_mode_e m, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] e, input int lat);
        send(m, a, b, e);
        collect(tag, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        d_valid   = 1'b0;
        d_mode    = 4'h0;
        d_x       = '0;
        d_y       = '0;
        out_ready = 1'b1;
        use_u     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid_s}, 0);
        chk("rst_busy",      {31'b0, busy_s}, 0);
        chk("rst_z",         z_s, 0);
        chk("rst_in_ready",  {31'b0, in_ready_s}, 1);
        rst_n = 1'b1;
        @(negedge clk);

        run("add",  MODE_ADD,  32'h33333333, 32'h02222222, 32'h35555555, 1);
        run("sub",  MODE_SUB,  32'h33333333, 32'h02222222, 32'h31111111, 1);
        run("slt",  MODE_SLT,  32'h33333333, 32'hffffffff, 32'h00000000, 1);
        run("slt1", MODE_SLT,  32'hfffffff0, 32'h00000001, 32'h00000001, 1);
        run("eq",   MODE_EQ,   32'h11111111, 32'h11111111, 32'h00000001, 1);
        run("neq",  MODE_NEQ,  32'h11111111, 32'h11111111, 32'h00000000, 1);
        run("sll",  MODE_SLL,  32'h00000001, 32'h00000024, 32'h00000010, 1);
        run("srl",  MODE_SRL,  32'h80000000, 32'h0000001f, 32'h00000001, 1);
        run("and",  MODE_AND,  32'hf0f0ff00, 32'h0ff0f0f0, 32'h00f0f000, 1);
        run("or",   MODE_OR,   32'hf0f00000, 32'h0000000f, 32'hf0f0000f, 1);
        run("xor",  MODE_XOR,  32'hffff0000, 32'hff00ff00, 32'h00ffff00, 1);
        run("nor",  MODE_NOR,  32'hffff0000, 32'h0000ff00, 32'h000000ff, 1);
        run("nop",  MODE_NOP,  32'h12345678, 32'h9abcdef0, 32'h00000000, 1);
        run("mfhi_rst", MODE_MFHI, 32'h0, 32'h0, 32'h00000000, 1);

        run("mul",      MODE_MUL,  32'h00000007, 32'hfffffffd, 32'hffffffeb, 33);
        run("mul_hi",   MODE_MFHI, 32'h0, 32'h0, 32'hffffffff, 1);
        run("mul_lo",   MODE_MFLO, 32'h0, 32'h0, 32'hffffffeb, 1);
        run("div",      MODE_DIV,  32'h33333333, 32'h02222222, 32'h00000018, 33);
        run("add_keep", MODE_ADD,  32'h00000001, 32'h00000001, 32'h00000002, 1);
        run("div_hi",   MODE_MFHI, 32'h0, 32'h0, 32'h00000003, 1);
        run("sdiv",     MODE_DIV,  32'hfffffff9, 32'h00000002, 32'hfffffffd, 33);
        run("sdiv_hi",  MODE_MFHI, 32'h0, 32'h0, 32'hffffffff, 1);
        run("div0",     MODE_DIV,  32'h00000005, 32'h00000000, 32'hffffffff, 33);
        run("div0_hi",  MODE_MFHI, 32'h0, 32'h0, 32'h00000005, 1);
        run("ovf",      MODE_DIV,  32'h80000000, 32'hffffffff, 32'h80000000, 33);
        run("ovf_hi",   MODE_MFHI, 32'h0, 32'h0, 32'h00000000, 1);

        // Backpressure: result held while the next op waits at the input.
        send(MODE_ADD, 32'h33333333, 32'h02222222, 32'h35555555);
        out_ready = 1'b0;
        d_mode    = MODE_SUB;
        d_x       = 32'h33333333;
        d_y       = 32'h02222222;
        d_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_z",         z_s, 32'h35555555);
            chk("bp_out_valid", {31'b0, out_valid_s}, 1);
            chk("bp_in_ready",  {31'b0, in_ready_s}, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, in_ready_s}, 1);
        chk("bp_add", z_s, exp_q.pop_front());
        @(posedge clk);
        exp_q.push_back(32'h31111111);
        @(negedge clk);
        d_valid = 1'b0;
        collect("bp_sub", 1);
        chk("bp_no_dup", {31'b0, out_valid_s}, 0);
        chk("bp_queue",  N'(exp_q.size()), 0);

        use_u = 1'b1;
        run("udiv",    MODE_DIV,  32'hffffffff, 32'h00000002, 32'h7fffffff, 33);
        run("udiv_hi", MODE_MFHI, 32'h0, 32'h0, 32'h00000001, 1);
        use_u = 1'b0;

        // Reset in the middle of a DIV discards it entirely.
        send(MODE_DIV, 32'h00000040, 32'h00000003, 32'h00000015);
        repeat (9) @(negedge clk);
        chk("mid_busy", {31'b0, busy_s}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid_s}, 0);
        chk("mid_rst_busy",      {31'b0, busy_s}, 0);
        chk("mid_rst_z",         z_s, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {31'b0, out_valid_s}, 0);
        run("post_add", MODE_ADD,  32'h00000001, 32'h00000001, 32'h00000002, 1);
        run("post_hi",  MODE_MFHI, 32'h0, 32'h0, 32'h00000000, 1);
        run("post_lo",  MODE_MFLO, 32'h0, 32'h0, 32'h00000000, 1);
        repeat (3) @(negedge clk);
        chk("post_quiet", {31'b0, out_valid_s}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
